// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Default geometry, nibble width and active-low "off" values for segments.
package seg7_scan_ctrl_pkg;

    localparam int unsigned SEG7_NIB_W            = 4;
    localparam int unsigned SEG7_NDIG_DEF         = 4;
    localparam int unsigned SEG7_DIV_DEF          = 50000;
    localparam int unsigned SEG7_DEAD_DEF         = 500;
    localparam int unsigned SEG7_BLINK_FRAMES_DEF = 64;

    localparam logic [7:0]  SEG7_SEG_OFF          = 8'hFF;

    typedef enum logic {
        PH_DEAD = 1'b0,
        PH_SHOW = 1'b1
    } slot_phase_e;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int unsigned seg7_cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_lzb.sv
// Leading-zero blanking mask: a digit is blanked when it and every digit
// above it are zero; the rightmost digit is always kept.
module seg7_scan_ctrl_lzb
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int unsigned NDIG = SEG7_NDIG_DEF
) (
    input  logic [NDIG-1:0][SEG7_NIB_W-1:0] data_i,
    input  logic                            lzb_i,
    output logic [NDIG-1:0]                 blank_o
);

    logic zero_above;

    always_comb begin
        blank_o    = '0;
        zero_above = 1'b1;
        for (int i = int'(NDIG) - 1; i >= 1; i--) begin
            zero_above = zero_above & (data_i[i] == '0);
            blank_o[i] = lzb_i & zero_above;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode scan controller with dead time between digits,
// double-buffered image, leading-zero blanking and per-digit blink.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int unsigned NDIG         = SEG7_NDIG_DEF,
    parameter int unsigned DIV          = SEG7_DIV_DEF,
    parameter int unsigned DEAD         = SEG7_DEAD_DEF,
    parameter int unsigned BLINK_FRAMES = SEG7_BLINK_FRAMES_DEF
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         LOAD,
    input  logic [SEG7_NIB_W*NDIG-1:0]   DATA,
    input  logic [NDIG-1:0]              DOTS,
    input  logic [NDIG-1:0]              BLINK,
    input  logic                         LZB,
    output logic [SEG7_NIB_W-1:0]        DIN,
    output logic                         EN,
    output logic                         DOT,
    output logic [NDIG-1:0]              nAN,
    output logic                         FRAME
);

    localparam int unsigned CNT_W  = seg7_cnt_w(DIV);
    localparam int unsigned IDX_W  = seg7_cnt_w(NDIG);
    localparam int unsigned BCNT_W = seg7_cnt_w(BLINK_FRAMES);
    localparam logic [NDIG-1:0] AN_OFF = {NDIG{1'b1}};

    typedef struct packed {
        logic [NDIG-1:0][SEG7_NIB_W-1:0] data;
        logic [NDIG-1:0]                 dots;
        logic [NDIG-1:0]                 blink;
        logic                            lzb;
    } img_t;

    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic [BCNT_W-1:0]     bcnt_q,    bcnt_d;
    logic                  phase_q,   phase_d;
    logic                  pend_q,    pend_d;
    img_t                  pending_q, pending_d;
    img_t                  shadow_q,  shadow_d;

    logic [NDIG-1:0]       nan_q,     nan_d;
    logic [SEG7_NIB_W-1:0] din_q,     din_d;
    logic                  en_q,      en_d;
    logic                  dot_q,     dot_d;
    logic                  frame_q;

    img_t                  in_img_c;
    logic                  slot_end_c;
    logic                  boundary_c;
    slot_phase_e           slot_ph_c;
    logic [NDIG-1:0]       lz_blank_c;
    logic [NDIG-1:0]       dark_c;

    always_comb begin
        in_img_c.data  = DATA;
        in_img_c.dots  = DOTS;
        in_img_c.blink = BLINK;
        in_img_c.lzb   = LZB;
    end

    assign slot_end_c = (cnt_q == CNT_W'(DIV - 1));
    assign boundary_c = slot_end_c && (idx_q == IDX_W'(NDIG - 1));

    seg7_scan_ctrl_lzb #(
        .NDIG    (NDIG)
    ) u_lzb (
        .data_i  (shadow_q.data),
        .lzb_i   (shadow_q.lzb),
        .blank_o (lz_blank_c)
    );

    assign dark_c = lz_blank_c | (shadow_q.blink & {NDIG{phase_q}});

    // Slot/digit counters, blink divider and the pending -> shadow image hand-off.
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        bcnt_d    = bcnt_q;
        phase_d   = phase_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        shadow_d  = shadow_q;

        if (slot_end_c) begin
            cnt_d = '0;
            idx_d = boundary_c ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (boundary_c) begin
            if (bcnt_q == BCNT_W'(BLINK_FRAMES - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + BCNT_W'(1);
            end
        end

        if (LOAD) begin
            pending_d = in_img_c;
        end

        // A LOAD landing exactly on the boundary goes straight to the shadow.
        if (boundary_c) begin
            pend_d = 1'b0;
            if (LOAD) begin
                shadow_d = in_img_c;
            end else if (pend_q) begin
                shadow_d = pending_q;
            end
        end else if (LOAD) begin
            pend_d = 1'b1;
        end
    end

    // Pin values for the current cnt/idx; registered, so pins trail by one cycle.
    always_comb begin
        slot_ph_c = (cnt_q >= CNT_W'(DEAD)) ? PH_SHOW : PH_DEAD;
        nan_d     = AN_OFF;
        din_d     = '0;
        dot_d     = 1'b0;
        en_d      = 1'b0;
        if (slot_ph_c == PH_SHOW) begin
            nan_d = ~(NDIG'(1) << idx_q);
            din_d = shadow_q.data[idx_q];
            dot_d = shadow_q.dots[idx_q];
            en_d  = ~dark_c[idx_q];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            bcnt_q    <= '0;
            phase_q   <= 1'b0;
            pend_q    <= 1'b0;
            pending_q <= '0;
            shadow_q  <= '0;
            nan_q     <= AN_OFF;
            din_q     <= '0;
            en_q      <= 1'b0;
            dot_q     <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            nan_q     <= nan_d;
            din_q     <= din_d;
            en_q      <= en_d;
            dot_q     <= dot_d;
            frame_q   <= boundary_c;
        end
    end

    assign nAN   = nan_q;
    assign DIN   = din_q;
    assign EN    = en_q;
    assign DOT   = dot_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus queues one expected image per
// frame, a monitor checks every pin cycle of each frame against it.
module tb_seg7_scan_ctrl;

    localparam int NDIG      = 4;
    localparam int DIV       = 8;
    localparam int DEAD      = 2;
    localparam int BF        = 2;
    localparam int FRAME_LEN = NDIG * DIV;

    logic        CLK = 1'b0;
    logic        RST;
    logic        LOAD;
    logic [15:0] DATA;
    logic [3:0]  DOTS;
    logic [3:0]  BLINK;
    logic        LZB;
    logic [3:0]  DIN;
    logic        EN;
    logic        DOT;
    logic [3:0]  nAN;
    logic        FRAME;

    seg7_scan_ctrl #(
        .NDIG         (NDIG),
        .DIV          (DIV),
        .DEAD         (DEAD),
        .BLINK_FRAMES (BF)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .LOAD  (LOAD),
        .DATA  (DATA),
        .DOTS  (DOTS),
        .BLINK (BLINK),
        .LZB   (LZB),
        .DIN   (DIN),
        .EN    (EN),
        .DOT   (DOT),
        .nAN   (nAN),
        .FRAME (FRAME)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]  en;
        logic [15:0] din;
        logic [3:0]  dot;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   fn     = 0;
    bit   in_reset = 1'b1;

    // Directed images with hand-derived enable masks for blink phase 0 / 1.
    logic [15:0] v_data [8] = '{16'h1234, 16'h0050, 16'h0000, 16'h1111,
                                16'h2222, 16'h0A07, 16'h8765, 16'h0000};
    logic [3:0]  v_dots [8] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000,
                                4'b0000, 4'b0010, 4'b0001, 4'b0000};
    logic [3:0]  v_blink[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                                4'b0000, 4'b0000, 4'b0001, 4'b0000};
    logic        v_lzb  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0]  v_en0  [8] = '{4'b1111, 4'b0011, 4'b0001, 4'b1111,
                                4'b1111, 4'b0111, 4'b1111, 4'b1111};
    logic [3:0]  v_en1  [8] = '{4'b1111, 4'b0011, 4'b0001, 4'b1111,
                                4'b1111, 4'b0111, 4'b1110, 4'b1111};

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] req_v);
        checks++;
        if (act_v !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act_v, req_v, $time);
        end
    endtask

    // Blink phase flips every BF frames, starting at 0 after reset.
    function automatic exp_t mk_exp(input int v, input int frame_no);
        exp_t e;
        e.en  = (((frame_no / BF) % 2) == 1) ? v_en1[v] : v_en0[v];
        e.din = v_data[v];
        e.dot = v_dots[v];
        return e;
    endfunction

    task automatic drive(input int v);
        LOAD  = 1'b1;
        DATA  = v_data[v];
        DOTS  = v_dots[v];
        BLINK = v_blink[v];
        LZB   = v_lzb[v];
    endtask

    // Called at the negedge where FRAME is visible; loads at frame positions p1/p2.
    task automatic run_frame(input int v1, input int p1, input int v2, input int p2, input int vexp);
        exp_q.push_back(mk_exp(vexp, fn + 1));
        for (int p = 0; p < FRAME_LEN; p++) begin
            LOAD = 1'b0;
            if (p == p1) drive(v1);
            if (p == p2) drive(v2);
            @(negedge CLK);
        end
        LOAD = 1'b0;
        check("frame_sync", 32'(FRAME), 32'd1);
        fn++;
    endtask

    // Called at the negedge where RST was released; runs up to the first FRAME.
    task automatic startup(input int v1, input int k1, input int vexp);
        fn = 0;
        exp_q.push_back(mk_exp(vexp, 1));
        for (int k = 0; k < FRAME_LEN; k++) begin
            LOAD = 1'b0;
            if (k == k1) drive(v1);
            if (k == 2) check("dead_after_rst", 32'(nAN), 32'hF);
            if (k == 3) begin
                check("first_show_an",  32'(nAN), 32'hE);
                check("first_show_en",  32'(EN),  32'd1);
                check("first_show_din", 32'(DIN), 32'd0);
            end
            @(negedge CLK);
        end
        LOAD = 1'b0;
        check("first_frame", 32'(FRAME), 32'd1);
        fn = 1;
    endtask

    exp_t       cur;
    int         mp  = 0;
    bit         act = 1'b0;
    logic [3:0] one_hot;
    logic [3:0] nan_e;
    logic [3:0] din_e;
    logic       en_e;
    logic       dot_e;

    // Monitor: one expected image per FRAME, checked at every pin cycle.
    always @(negedge CLK) begin
        check("onehot_an", 32'($countones(~nAN) <= 1), 32'd1);
        if (in_reset) begin
            act = 1'b0;
            mp  = 0;
            exp_q.delete();
        end else if (FRAME) begin
            if (act) begin
                check("frame_period", 32'(mp), 32'(FRAME_LEN - 1));
                check("last_an",  32'(nAN), 32'h7);
                check("last_en",  32'(EN),  32'(cur.en[3]));
                check("last_din", 32'(DIN), 32'(cur.din[15:12]));
                check("last_dot", 32'(DOT), 32'(cur.dot[3]));
            end
            if (exp_q.size() == 0) begin
                check("exp_available", 32'd0, 32'd1);
                act = 1'b0;
            end else begin
                cur = exp_q.pop_front();
                act = 1'b1;
            end
            mp = 0;
        end else if (act) begin
            mp++;
            if (mp >= FRAME_LEN) begin
                check("frame_period", 32'(mp), 32'(FRAME_LEN - 1));
                act = 1'b0;
            end else begin
                nan_e = 4'hF;
                din_e = 4'h0;
                en_e  = 1'b0;
                dot_e = 1'b0;
                if (((mp - 1) % DIV) >= DEAD) begin
                    one_hot = 4'b0001 << ((mp - 1) / DIV);
                    nan_e   = ~one_hot;
                    en_e    = cur.en[(mp - 1) / DIV];
                    din_e   = cur.din[((mp - 1) / DIV) * 4 +: 4];
                    dot_e   = cur.dot[(mp - 1) / DIV];
                end
                check("scan_an",  32'(nAN), 32'(nan_e));
                check("scan_en",  32'(EN),  32'(en_e));
                check("scan_din", 32'(DIN), 32'(din_e));
                check("scan_dot", 32'(DOT), 32'(dot_e));
            end
        end
    end

    initial begin
        RST   = 1'b1;
        LOAD  = 1'b0;
        DATA  = '0;
        DOTS  = '0;
        BLINK = '0;
        LZB   = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_an",    32'(nAN),   32'hF);
        check("rst_en",    32'(EN),    32'd0);
        check("rst_din",   32'(DIN),   32'd0);
        check("rst_dot",   32'(DOT),   32'd0);
        check("rst_frame", 32'(FRAME), 32'd0);
        RST      = 1'b0;
        in_reset = 1'b0;

        startup(0, 5, 0);
        run_frame(1, 2, -1, -1, 1);
        run_frame(2, 2, -1, -1, 2);
        run_frame(3, 2, 4, 15, 4);
        run_frame(-1, -1, -1, -1, 4);
        run_frame(5, FRAME_LEN - 1, -1, -1, 5);
        run_frame(6, 4, -1, -1, 6);
        run_frame(-1, -1, -1, -1, 6);
        run_frame(-1, -1, -1, -1, 6);
        run_frame(-1, -1, -1, -1, 6);
        run_frame(7, 3, -1, -1, 7);

        // Reset while digit 2 is lit: pins must go dark without waiting for a clock.
        repeat (20) @(negedge CLK);
        check("pre_rst_an", 32'(nAN), 32'hB);
        in_reset = 1'b1;
        RST      = 1'b1;
        #1;
        check("async_rst_an",    32'(nAN),   32'hF);
        check("async_rst_en",    32'(EN),    32'd0);
        check("async_rst_frame", 32'(FRAME), 32'd0);
        @(negedge CLK);
        RST      = 1'b0;
        in_reset = 1'b0;

        startup(-1, -1, 7);
        run_frame(0, 1, -1, -1, 0);
        run_frame(-1, -1, -1, -1, 0);
        repeat (4) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
